l1_mem_arbiter: RTL and testbench

- Two-client arbiter between the L1 instruction-side bus and the L1 data-side bus on one side, and the single SDRAM controller bus on the other.
- Sits directly downstream of the L1 instruction cache and its data-side counterpart, and directly upstream of the SDRAM controller.
- Serialises requests with registered round-robin grant, latches the winning request, holds it on the SDRAM bus until done, and routes the response back.

---
 rtl/mem_bus_pkg.sv | 7 +
 rtl/l1_mem_arbiter_rr_grant2.sv | 17 +
 rtl/l1_mem_arbiter.sv | 88 ++++++++
 tb/tb_l1_mem_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state/client enums and default bus widths for the L1 memory arbiter
package mem_bus_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;
  typedef enum logic {CL_I, CL_D} client_t;
endpackage

// File: rtl/l1_mem_arbiter_rr_grant2.sv
// rr_grant2: combinational 2-way picker (bit 0 = I, bit 1 = D), round-robin or D-first with L1_ARB_FIXED_PRIORITY_EN
module rr_grant2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  client_t    last_grant,
  output logic [1:0] grant
);
  // a lone request always wins; a tie goes to the preferred client
  always_comb begin
`ifdef L1_ARB_FIXED_PRIORITY_EN
    grant = (req == 2'b11) ? 2'b10 : req;
`else
    grant = (req == 2'b11) ? ((last_grant == CL_D) ? 2'b01 : 2'b10) : req;
`endif
  end
endmodule

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: serialises L1 I-side and D-side requests onto the SDRAM controller bus; L1_ARB_FIXED_PRIORITY_EN makes D win ties
module l1_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_we,
  input  logic              i_start,
  output logic [DATA_W-1:0] i_q,
  output logic              i_done,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  input  logic              d_start,
  output logic [DATA_W-1:0] d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [DATA_W-1:0] sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [DATA_W-1:0] sdc_q,
  input  logic              sdc_done
);
  state_t     state;
  client_t    last_grant;
  logic [2:0] gap_cnt;
  logic [1:0] grant;

  rr_grant2 u_grant (
    .req        ({d_start, i_start}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign i_q    = sdc_q;
  assign d_q    = sdc_q;
  assign i_done = (state == BUSY_I) && sdc_done;
  assign d_done = (state == BUSY_D) && sdc_done;

  // grant and latch in IDLE, hold until sdc_done, then a forced idle gap before re-sampling requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= CL_D;
      gap_cnt    <= '0;
      sdc_start  <= 1'b0;
      sdc_we     <= 1'b0;
      sdc_addr   <= '0;
      sdc_data   <= '0;
    end else begin
      case (state)
        IDLE:
          if (grant[0]) begin
            sdc_addr  <= i_addr;
            sdc_data  <= i_data;
            sdc_we    <= i_we;
            sdc_start <= 1'b1;
            state     <= BUSY_I;
          end else if (grant[1]) begin
            sdc_addr  <= d_addr;
            sdc_data  <= d_data;
            sdc_we    <= d_we;
            sdc_start <= 1'b1;
            state     <= BUSY_D;
          end
        BUSY_I, BUSY_D:
          if (sdc_done) begin
            sdc_start  <= 1'b0;
            sdc_we     <= 1'b0;
            last_grant <= (state == BUSY_I) ? CL_I : CL_D;
            gap_cnt    <= GAP_CYCLES[2:0];
            state      <= GAP;
          end
        GAP: begin
          gap_cnt <= gap_cnt - 3'd1;
          if (gap_cnt <= 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed self-checking bench for l1_mem_arbiter (GAP_CYCLES=1)
module tb_l1_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_addr = '0, i_data = '0, d_addr = '0, d_data = '0, sdc_q = '0;
  logic        i_we = 1'b0, i_start = 1'b0, d_we = 1'b0, d_start = 1'b0, sdc_done = 1'b0;
  logic [31:0] i_q, d_q, sdc_addr, sdc_data;
  logic        i_done, d_done, sdc_we, sdc_start;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        first_d;

  l1_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_we      (i_we),
    .i_start   (i_start),
    .i_q       (i_q),
    .i_done    (i_done),
    .d_addr    (d_addr),
    .d_data    (d_data),
    .d_we      (d_we),
    .d_start   (d_start),
    .d_q       (d_q),
    .d_done    (d_done),
    .sdc_addr  (sdc_addr),
    .sdc_data  (sdc_data),
    .sdc_we    (sdc_we),
    .sdc_start (sdc_start),
    .sdc_q     (sdc_q),
    .sdc_done  (sdc_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge in IDLE with the request(s) driven; returns at the negedge where the arbiter is IDLE again
  task automatic serve(input string tag, input logic is_d, input logic [31:0] addr, input logic [31:0] q);
    @(negedge clk);
    check({tag, "_start"}, sdc_start, 1);
    check({tag, "_addr"}, sdc_addr, addr);
    sdc_q = q;
    sdc_done = 1'b1;
    #1;
    check({tag, "_idone"}, i_done, !is_d);
    check({tag, "_ddone"}, d_done, is_d);
    check({tag, "_q"}, is_d ? d_q : i_q, q);
    @(negedge clk);
    sdc_done = 1'b0;
    if (is_d) d_start = 1'b0; else i_start = 1'b0;
    check({tag, "_gap"}, sdc_start, 0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    sdc_done = 1'b1;
    #12;
    check("rst_start", sdc_start, 0);
    check("rst_addr", sdc_addr, 0);
    check("rst_data", sdc_data, 0);
    check("rst_we", sdc_we, 0);
    check("rst_idone", i_done, 0);
    check("rst_ddone", d_done, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_done_i", i_done, 0);
    check("idle_done_d", d_done, 0);
    @(negedge clk);
    sdc_done = 1'b0;
    check("idle_nostart", sdc_start, 0);

    i_addr = 32'h100;
    i_start = 1'b1;
    serve("t1", 1'b0, 32'h100, 32'hDEADBEEF);

    i_addr = 32'h200;
    d_addr = 32'h300;
    i_start = 1'b1;
    d_start = 1'b1;
    serve("alt_d", 1'b1, 32'h300, 32'h11111111);
    serve("alt_i", 1'b0, 32'h200, 32'h22222222);

    pulse_reset();
`ifdef L1_ARB_FIXED_PRIORITY_EN
    first_d = 1'b1;
`else
    first_d = 1'b0;
`endif
    i_start = 1'b1;
    d_start = 1'b1;
    serve("tie1", first_d, first_d ? 32'h300 : 32'h200, 32'h33333333);
    serve("tie2", !first_d, first_d ? 32'h200 : 32'h300, 32'h44444444);

    d_addr = 32'h40;
    d_data = 32'h12345678;
    d_we = 1'b1;
    d_start = 1'b1;
    @(negedge clk);
    check("wr_we", sdc_we, 1);
    check("wr_data", sdc_data, 32'h12345678);
    check("wr_addr", sdc_addr, 32'h40);
    @(negedge clk);
    check("wr_we_hold", sdc_we, 1);
    check("wr_data_hold", sdc_data, 32'h12345678);
    sdc_done = 1'b1;
    #1;
    check("wr_ddone", d_done, 1);
    @(negedge clk);
    sdc_done = 1'b0;
    d_start = 1'b0;
    d_we = 1'b0;
    check("wr_we_clr", sdc_we, 0);
    @(negedge clk);

    i_addr = 32'h500;
    i_start = 1'b1;
    @(negedge clk);
    check("bi_addr", sdc_addr, 32'h500);
    i_addr = 32'h600;
    d_addr = 32'h700;
    d_start = 1'b1;
    @(negedge clk);
    check("bi_addr_hold", sdc_addr, 32'h500);
    check("bi_start_hold", sdc_start, 1);
    sdc_done = 1'b1;
    #1;
    check("bi_idone", i_done, 1);
    check("bi_ddone", d_done, 0);
    @(negedge clk);
    sdc_done = 1'b0;
    i_start = 1'b0;
    check("bi_gap", sdc_start, 0);
    @(negedge clk);
    serve("bi_d", 1'b1, 32'h700, 32'h55555555);

    d_addr = 32'h80;
    d_start = 1'b1;
    @(negedge clk);
    check("rm_busy", sdc_start, 1);
    #2;
    reset = 1'b0;
    sdc_done = 1'b1;
    #1;
    check("rm_start", sdc_start, 0);
    check("rm_addr", sdc_addr, 0);
    check("rm_ddone", d_done, 0);
    @(negedge clk);
    check("rm_ddone2", d_done, 0);
    sdc_done = 1'b0;
    d_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rm_idle", sdc_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
